// File: rtl/counter_stim_driver.sv
// Command-driven stimulus generator for the 16-bit up/down counter.
// Accepts HOLD/LOAD/UP/DOWN commands over valid/ready, drives the counter
// controls for cmd_len+1 cycles, and predicts the counter's data_out.
// Ports:
//   clk, rst_                  clock, async active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/cmd_data/cmd_len    command fields, sampled at the handshake edge
//   data_in/ld_cnt/updn_cnt/count_enb  counter controls
//   busy, done                 status; done is a one-cycle completion pulse
//   expected_out               cycle-aligned prediction of counter data_out
module counter_stim_driver #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [LEN_W-1:0] cmd_len,
  output logic [WIDTH-1:0] data_in,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] expected_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_DRIVE = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   data_in_q, data_in_d;
  logic               ld_cnt_q, ld_cnt_d;
  logic               updn_q, updn_d;
  logic               enb_q, enb_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready_q, ready_d;
  logic [WIDTH-1:0]   exp_q, exp_d;

  // Next-state, control pattern and counter prediction.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    data_in_d = data_in_q;
    ld_cnt_d  = ld_cnt_q;
    updn_d    = updn_q;
    enb_d     = enb_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ready_d   = ready_q;
    exp_d     = exp_q;

    // Prediction uses the controls presented during the cycle ending now,
    // which is exactly what the counter samples on this edge.
    if (!ld_cnt_q) begin
      exp_d = data_in_q;
    end else if (enb_q) begin
      exp_d = updn_q ? exp_q + WIDTH'(1) : exp_q - WIDTH'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && ready_q) begin
          rem_d   = cmd_len;
          state_d = ST_DRIVE;
          busy_d  = 1'b1;
          ready_d = 1'b0;
          case (cmd_op)
            OP_HOLD: begin
              ld_cnt_d = 1'b1;
              enb_d    = 1'b0;
            end
            OP_LOAD: begin
              ld_cnt_d  = 1'b0;
              data_in_d = cmd_data;
              enb_d     = 1'b0;
            end
            OP_UP: begin
              ld_cnt_d = 1'b1;
              enb_d    = 1'b1;
              updn_d   = 1'b1;
            end
            OP_DOWN: begin
              ld_cnt_d = 1'b1;
              enb_d    = 1'b1;
              updn_d   = 1'b0;
            end
            default: begin
              ld_cnt_d = 1'b1;
              enb_d    = 1'b0;
            end
          endcase
        end
      end
      ST_DRIVE: begin
        if (rem_q == '0) begin
          ld_cnt_d = 1'b1;
          enb_d    = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_DONE;
        end else begin
          rem_d = rem_q - LEN_W'(1);
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
        ld_cnt_d = 1'b1;
        enb_d   = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= ST_IDLE;
      rem_q     <= '0;
      data_in_q <= '0;
      ld_cnt_q  <= 1'b1;
      updn_q    <= 1'b0;
      enb_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      data_in_q <= data_in_d;
      ld_cnt_q  <= ld_cnt_d;
      updn_q    <= updn_d;
      enb_q     <= enb_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      exp_q     <= exp_d;
    end
  end

  assign cmd_ready    = ready_q;
  assign data_in      = data_in_q;
  assign ld_cnt       = ld_cnt_q;
  assign updn_cnt     = updn_q;
  assign count_enb    = enb_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign expected_out = exp_q;

endmodule

// File: tb/tb_counter_stim_driver.sv
// Self-checking bench for counter_stim_driver: table of directed commands
// plus hand-written sequences for queued commands and mid-command reset.
module tb_counter_stim_driver;

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;
  localparam logic [1:0] OP_UP   = 2'b10;
  localparam logic [1:0] OP_DOWN = 2'b11;

  logic        clk;
  logic        rst_;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic [7:0]  cmd_len;
  logic [15:0] data_in;
  logic        ld_cnt;
  logic        updn_cnt;
  logic        count_enb;
  logic        busy;
  logic        done;
  logic [15:0] expected_out;

  int tests;
  int fails;
  logic [15:0] m;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] data;
    logic [7:0]  len;
    logic [15:0] final_exp;
  } vec_t;

  vec_t vecs [9];

  counter_stim_driver #(.WIDTH(16), .LEN_W(8)) dut (
    .clk          (clk),
    .rst_         (rst_),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_len      (cmd_len),
    .data_in      (data_in),
    .ld_cnt       (ld_cnt),
    .updn_cnt     (updn_cnt),
    .count_enb    (count_enb),
    .busy         (busy),
    .done         (done),
    .expected_out (expected_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkw(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %04h expected %04h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [1:0] op, input logic [15:0] d,
                                       input logic [15:0] cur);
    case (op)
      OP_LOAD: step = d;
      OP_UP:   step = cur + 16'd1;
      OP_DOWN: step = cur - 16'd1;
      default: step = cur;
    endcase
  endfunction

  // Wait (bounded) for ready, then present a command for one handshake edge.
  task automatic issue(input logic [1:0] op, input logic [15:0] d, input logic [7:0] len);
    int n;
    n = 0;
    while (!cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check1("ready_wait", cmd_ready, 1'b1);
    cmd_op    = op;
    cmd_data  = d;
    cmd_len   = len;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // Called in the first drive cycle; checks every drive cycle, DONE and IDLE.
  task automatic follow(input logic [1:0] op, input logic [15:0] d, input logic [7:0] len);
    logic exp_enb;
    exp_enb = (op == OP_UP) || (op == OP_DOWN);
    for (int i = 0; i <= int'(len); i++) begin
      check1("drv_ld_cnt", ld_cnt, (op == OP_LOAD) ? 1'b0 : 1'b1);
      check1("drv_count_enb", count_enb, exp_enb);
      if (exp_enb) check1("drv_updn", updn_cnt, (op == OP_UP));
      if (op == OP_LOAD) checkw("drv_data_in", data_in, d);
      check1("drv_no_ld_with_enb", (!ld_cnt) && count_enb, 1'b0);
      check1("drv_busy", busy, 1'b1);
      check1("drv_ready", cmd_ready, 1'b0);
      check1("drv_done", done, 1'b0);
      checkw("drv_expected", expected_out, m);
      m = step(op, d, m);
      tick();
    end
    check1("done_pulse", done, 1'b1);
    check1("done_busy", busy, 1'b1);
    check1("done_ready", cmd_ready, 1'b0);
    check1("done_ld_cnt", ld_cnt, 1'b1);
    check1("done_count_enb", count_enb, 1'b0);
    checkw("done_expected", expected_out, m);
    tick();
    check1("idle_done", done, 1'b0);
    check1("idle_busy", busy, 1'b0);
    check1("idle_ready", cmd_ready, 1'b1);
    checkw("idle_expected", expected_out, m);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    m = 16'h0000;
    vecs[0] = '{OP_LOAD, 16'h1234, 8'd0,   16'h1234};
    vecs[1] = '{OP_LOAD, 16'hFFFE, 8'd0,   16'hFFFE};
    vecs[2] = '{OP_UP,   16'h0000, 8'd3,   16'h0002};
    vecs[3] = '{OP_LOAD, 16'h0000, 8'd0,   16'h0000};
    vecs[4] = '{OP_DOWN, 16'h0000, 8'd1,   16'hFFFE};
    vecs[5] = '{OP_HOLD, 16'h5555, 8'd2,   16'hFFFE};
    vecs[6] = '{OP_LOAD, 16'h8000, 8'd0,   16'h8000};
    vecs[7] = '{OP_DOWN, 16'h0000, 8'd0,   16'h7FFF};
    vecs[8] = '{OP_UP,   16'h0000, 8'd255, 16'h80FF};

    rst_      = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = OP_HOLD;
    cmd_data  = 16'h0000;
    cmd_len   = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b1;
    check1("rst_ld_cnt", ld_cnt, 1'b1);
    check1("rst_count_enb", count_enb, 1'b0);
    check1("rst_updn", updn_cnt, 1'b0);
    checkw("rst_data_in", data_in, 16'h0000);
    checkw("rst_expected", expected_out, 16'h0000);
    check1("rst_busy", busy, 1'b0);
    check1("rst_done", done, 1'b0);
    check1("rst_ready", cmd_ready, 1'b1);
    tick();
    check1("post_rst_done", done, 1'b0);
    checkw("post_rst_expected", expected_out, 16'h0000);

    for (int v = 0; v < 9; v++) begin
      issue(vecs[v].op, vecs[v].data, vecs[v].len);
      follow(vecs[v].op, vecs[v].data, vecs[v].len);
      checkw("vec_final", expected_out, vecs[v].final_exp);
    end

    // Queued command: valid stays high through a HOLD; fields change while busy.
    cmd_op    = OP_HOLD;
    cmd_data  = 16'h0000;
    cmd_len   = 8'd4;
    cmd_valid = 1'b1;
    tick();
    cmd_op   = OP_UP;
    cmd_data = 16'hDEAD;
    cmd_len  = 8'd2;
    follow(OP_HOLD, 16'h0000, 8'd4);
    checkw("hold_unchanged", expected_out, 16'h80FF);
    tick();
    cmd_valid = 1'b0;
    follow(OP_UP, 16'hDEAD, 8'd2);
    checkw("queued_up_final", expected_out, 16'h8102);

    // Reset in the middle of a long UP.
    issue(OP_LOAD, 16'h0010, 8'd0);
    follow(OP_LOAD, 16'h0010, 8'd0);
    issue(OP_UP, 16'h0000, 8'd10);
    check1("up_started", count_enb, 1'b1);
    tick();
    tick();
    tick();
    checkw("up_progress", expected_out, 16'h0013);
    #2;
    rst_ = 1'b0;
    #1;
    check1("async_ld_cnt", ld_cnt, 1'b1);
    check1("async_count_enb", count_enb, 1'b0);
    checkw("async_expected", expected_out, 16'h0000);
    check1("async_busy", busy, 1'b0);
    check1("async_ready", cmd_ready, 1'b1);
    check1("async_done", done, 1'b0);
    repeat (2) begin
      tick();
      check1("in_rst_done", done, 1'b0);
      check1("in_rst_busy", busy, 1'b0);
    end
    rst_ = 1'b1;
    m = 16'h0000;
    issue(OP_LOAD, 16'h00AA, 8'd0);
    follow(OP_LOAD, 16'h00AA, 8'd0);
    checkw("after_rst_final", expected_out, 16'h00AA);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_stim_driver.md
Name: counter_stim_driver

Overview:
Synthesizable command-driven stimulus generator for the 16-bit up/down counter. It is the driving end of the counter control interface (data_in, ld_cnt, updn_cnt, count_enb); the property checker is the observing end. It accepts commands over a valid/ready handshake, drives the counter controls for a programmed number of cycles, and keeps a cycle-aligned prediction of the counter's data_out for scoreboard comparison.

Parameters:
WIDTH, 16, counter data width (data_in, cmd_data, expected_out)
LEN_W, 8, width of the command repeat-length field

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept a command (IDLE only)
cmd_op  input  2  00 HOLD, 01 LOAD, 10 UP, 11 DOWN
cmd_data  input  WIDTH  load value, used for LOAD only
cmd_len  input  LEN_W  drive length; the command is driven for cmd_len+1 cycles
data_in  output  WIDTH  to counter load data
ld_cnt  output  1  to counter; active-low load
updn_cnt  output  1  to counter; 1 = up, 0 = down
count_enb  output  1  to counter; active-high count enable
busy  output  1  state != IDLE
done  output  1  single-cycle pulse when a command completes
expected_out  output  WIDTH  predicted counter data_out

Behaviour:
- Single clock domain; one clock; reset is asynchronous and active-low (rst_).
- All outputs are registered.
- Reset values, applied immediately on rst_ low:
  - ld_cnt=1, count_enb=0, updn_cnt=0, data_in=0
  - expected_out=0, busy=0, done=0, cmd_ready=1
  - FSM=IDLE, internal length counter=0
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - cmd_ready=1.
  - A handshake occurs on an edge with cmd_valid && cmd_ready.
  - At that edge: latch op, data and len; load the remaining-cycle counter with cmd_len; drive the first cycle's control values; go to DRIVE.
- DRIVE:
  - cmd_ready=0. The control pattern is held for exactly cmd_len+1 cycles.
  - HOLD: ld_cnt=1, count_enb=0.
  - LOAD: ld_cnt=0, data_in=latched data, count_enb=0.
  - UP: ld_cnt=1, count_enb=1, updn_cnt=1.
  - DOWN: ld_cnt=1, count_enb=1, updn_cnt=0.
  - ld_cnt=0 and count_enb=1 are never driven together.
  - On the edge ending the last drive cycle (remaining==0): outputs return to idle values (ld_cnt=1, count_enb=0; data_in and updn_cnt keep their last values); go to DONE.
- DONE:
  - done=1 for exactly one cycle, cmd_ready=0.
  - Next edge: done=0, go to IDLE.
  - Back-to-back command accept rate is therefore one command per len+3 cycles.
- expected_out updates on every rising edge from the control values present before that edge, matching the counter's sampling:
  - ld_cnt==0: load data_in.
  - else count_enb==1: ±1 per updn_cnt, modulo 2^WIDTH (0xFFFF+1 = 0x0000, 0x0000−1 = 0xFFFF).
  - else: hold.
- Command fields are sampled only at the handshake edge. Changes to cmd_* while busy are ignored. cmd_valid held high while busy is not lost: it is accepted at the next IDLE edge.
- cmd_len=0: exactly one drive cycle. Maximum length (2^LEN_W−1) gives 2^LEN_W drive cycles.
- Reset mid-DRIVE or mid-DONE: the command is dropped and all reset values are applied asynchronously. The first accept is possible at the first edge after rst_ rises.

Test Plan:
1. Hold rst_=0 for 3 cycles, then release -> all outputs at their reset values; cmd_ready=1; expected_out=0x0000; no done pulse.
2. LOAD cmd_data=0x1234, cmd_len=0 -> ld_cnt=0 with data_in=0x1234 for exactly 1 cycle; count_enb stays 0; expected_out=0x1234 one edge later; done high 1 cycle after the drive cycle; busy for 2 cycles.
3. LOAD 0xFFFE, then UP cmd_len=3 -> count_enb=1, updn_cnt=1 for 4 cycles; expected_out sequence 0xFFFF, 0x0000, 0x0001, 0x0002; then holds at 0x0002.
4. LOAD 0x0000, then DOWN cmd_len=1 -> expected_out 0xFFFF, 0xFFFE; ld_cnt stays 1 throughout the DOWN command.
5. HOLD cmd_len=4 issued while cmd_valid stays high with a queued UP -> cmd_ready=0 for the 6 busy cycles; expected_out unchanged during HOLD; the UP is accepted on the first IDLE edge and executes normally.
6. UP cmd_len=10 from 0x0010, rst_ pulsed low after 3 drive cycles -> ld_cnt=1, count_enb=0, expected_out=0x0000, busy=0 immediately without waiting for a clock; no done pulse; a new LOAD 0x00AA is accepted after release and completes normally.
